// File: rtl/alu_writeback_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_writeback_if : valid/ready result bus from the ALU into writeback       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface alu_writeback_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
);
   logic              wb_valid;
   logic              wb_ready;
   logic [ADDR_W-1:0] wb_rd;
   logic [DATA_W-1:0] wb_result;
   logic              wb_zero;
   logic              wb_negative;
   logic              wb_write_reg;
   logic              wb_set_flags;

   modport master (
      output wb_valid, wb_rd, wb_result, wb_zero, wb_negative,
             wb_write_reg, wb_set_flags,
      input  wb_ready
   );

   modport slave (
      input  wb_valid, wb_rd, wb_result, wb_zero, wb_negative,
             wb_write_reg, wb_set_flags,
      output wb_ready
   );
endinterface
`default_nettype wire

// File: rtl/alu_writeback.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_writeback : one-entry writeback register, register file, Z/N flags.    |
// | Optional macro WB_FORWARD_EN: read ports bypass the pending entry.          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module alu_writeback #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_writeback_if.slave    wb,
   input  logic              stall_i,
   input  logic [ADDR_W-1:0] rh_addr_i,
   input  logic [ADDR_W-1:0] ro_addr_i,
   output logic [DATA_W-1:0] rh_value_o,
   output logic [DATA_W-1:0] ro_value_o,
   output logic              flag_z_o,
   output logic              flag_n_o,
   output logic              pending_o
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic              flag_z_q, flag_n_q;

   logic              valid_q,     valid_d;
   logic [ADDR_W-1:0] rd_q,        rd_d;
   logic [DATA_W-1:0] result_q,    result_d;
   logic              z_q,         z_d;
   logic              n_q,         n_d;
   logic              write_reg_q, write_reg_d;
   logic              set_flags_q, set_flags_d;

   logic              commit;
   logic              accept;
   logic              rd_ok, rh_ok, ro_ok;

   // Free slot, or the held entry retires on this same edge.
   assign wb.wb_ready = !valid_q || !stall_i;
   assign commit      = valid_q && !stall_i;
   assign accept      = wb.wb_valid && wb.wb_ready;

   // Indices past the populated part of the address space write nowhere and read 0.
   generate
      if (NUM_REGS < (1 << ADDR_W)) begin : g_partial_map
         assign rd_ok = (32'(rd_q)      < NUM_REGS);
         assign rh_ok = (32'(rh_addr_i) < NUM_REGS);
         assign ro_ok = (32'(ro_addr_i) < NUM_REGS);
      end else begin : g_full_map
         assign rd_ok = 1'b1;
         assign rh_ok = 1'b1;
         assign ro_ok = 1'b1;
      end
   endgenerate

   always_comb begin
      valid_d     = valid_q;
      rd_d        = rd_q;
      result_d    = result_q;
      z_d         = z_q;
      n_d         = n_q;
      write_reg_d = write_reg_q;
      set_flags_d = set_flags_q;
      if (commit) begin
         valid_d = 1'b0;
      end
      if (accept) begin
         valid_d     = 1'b1;
         rd_d        = wb.wb_rd;
         result_d    = wb.wb_result;
         z_d         = wb.wb_zero;
         n_d         = wb.wb_negative;
         write_reg_d = wb.wb_write_reg;
         set_flags_d = wb.wb_set_flags;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         rd_q        <= '0;
         result_q    <= '0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
         write_reg_q <= 1'b0;
         set_flags_q <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         rd_q        <= rd_d;
         result_q    <= result_d;
         z_q         <= z_d;
         n_q         <= n_d;
         write_reg_q <= write_reg_d;
         set_flags_q <= set_flags_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         flag_z_q <= 1'b0;
         flag_n_q <= 1'b0;
      end else if (commit) begin
         if (write_reg_q && rd_ok) begin
            regs_q[rd_q] <= result_q;
         end
         if (set_flags_q) begin
            flag_z_q <= z_q;
            flag_n_q <= n_q;
         end
      end
   end

   always_comb begin
      rh_value_o = '0;
      ro_value_o = '0;
      if (rh_ok) rh_value_o = regs_q[rh_addr_i];
      if (ro_ok) ro_value_o = regs_q[ro_addr_i];
`ifdef WB_FORWARD_EN
      // Only register data is bypassed; flags always reflect committed state.
      if (valid_q && write_reg_q && rd_ok && (rd_q == rh_addr_i)) rh_value_o = result_q;
      if (valid_q && write_reg_q && rd_ok && (rd_q == ro_addr_i)) ro_value_o = result_q;
`else
`endif
   end

   assign flag_z_o  = flag_z_q;
   assign flag_n_o  = flag_n_q;
   assign pending_o = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for alu_writeback: directed scenarios plus a randomized
// stream compared against a transaction-level model of the writeback stage.
module tb_alu_writeback;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 16;
   localparam int ADDR_W   = 4;

   logic              clk     = 1'b0;
   logic              rst_n   = 1'b1;
   logic              stall   = 1'b0;
   logic [ADDR_W-1:0] rh_addr = '0;
   logic [ADDR_W-1:0] ro_addr = '0;
   logic [DATA_W-1:0] rh_value, ro_value;
   logic              flag_z, flag_n, pending;

   int n_vec = 0;
   int n_err = 0;

`ifdef WB_FORWARD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   alu_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb_if ();

   alu_writeback #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wb         (wb_if),
      .stall_i    (stall),
      .rh_addr_i  (rh_addr),
      .ro_addr_i  (ro_addr),
      .rh_value_o (rh_value),
      .ro_value_o (ro_value),
      .flag_z_o   (flag_z),
      .flag_n_o   (flag_n),
      .pending_o  (pending)
   );

   always #5 clk = ~clk;

   // Reference model: architectural state plus the one outstanding result.
   typedef struct {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] res;
      logic              z, n, wr, sf;
   } entry_t;

   logic [DATA_W-1:0] m_regs [NUM_REGS];
   logic              m_z, m_n, m_pend;
   entry_t            m_e;

   task automatic model_reset();
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
      m_z    = 1'b0;
      m_n    = 1'b0;
      m_pend = 1'b0;
   endtask

   function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
      if (FWD_ON && m_pend && m_e.wr && (m_e.rd == a)) return m_e.res;
      if (int'(a) < NUM_REGS) return m_regs[a];
      return '0;
   endfunction

   task automatic offer(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] res,
                        input logic z, input logic n, input logic wr, input logic sf);
      wb_if.wb_valid     = v;
      wb_if.wb_rd        = rd;
      wb_if.wb_result    = res;
      wb_if.wb_zero      = z;
      wb_if.wb_negative  = n;
      wb_if.wb_write_reg = wr;
      wb_if.wb_set_flags = sf;
   endtask

   // One clock: model retires/accepts using the inputs present at the edge,
   // then returns at the following falling edge where outputs are sampled.
   task automatic tick();
      logic room;
      @(posedge clk);
      room = !m_pend || !stall;
      if (m_pend && !stall) begin
         if (m_e.wr && int'(m_e.rd) < NUM_REGS) m_regs[m_e.rd] = m_e.res;
         if (m_e.sf) begin
            m_z = m_e.z;
            m_n = m_e.n;
         end
         m_pend = 1'b0;
      end
      if (wb_if.wb_valid && room) begin
         m_e.rd  = wb_if.wb_rd;
         m_e.res = wb_if.wb_result;
         m_e.z   = wb_if.wb_zero;
         m_e.n   = wb_if.wb_negative;
         m_e.wr  = wb_if.wb_write_reg;
         m_e.sf  = wb_if.wb_set_flags;
         m_pend  = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL reset_pending: got %b want 0", pending); end
      n_vec++; if (flag_z !== 1'b0) begin n_err++; $display("FAIL reset_flag_z: got %b want 0", flag_z); end
      n_vec++; if (flag_n !== 1'b0) begin n_err++; $display("FAIL reset_flag_n: got %b want 0", flag_n); end
      n_vec++; if (wb_if.wb_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", wb_if.wb_ready); end
      for (int i = 0; i < NUM_REGS; i++) begin
         rh_addr = ADDR_W'(i);
         ro_addr = ADDR_W'(NUM_REGS - 1 - i);
         #1;
         n_vec++; if (rh_value !== '0) begin n_err++; $display("FAIL reset_rh[%0d]: got %h want 0", i, rh_value); end
         n_vec++; if (ro_value !== '0) begin n_err++; $display("FAIL reset_ro[%0d]: got %h want 0", i, ro_value); end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_write();
      stall = 1'b0;
      offer(1'b1, 4'd3, 32'h0000_002A, 1'b0, 1'b0, 1'b1, 1'b1);
      rh_addr = 4'd3;
      ro_addr = 4'd3;
      #1;
      n_vec++; if (wb_if.wb_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", wb_if.wb_ready); end
      tick();
      offer(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL single_pending1: got %b want 1", pending); end
      n_vec++; if (rh_value !== (FWD_ON ? 32'h2A : 32'h0)) begin n_err++; $display("FAIL single_rh_before: got %h want %h", rh_value, FWD_ON ? 32'h2A : 32'h0); end
      tick();
      n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL single_pending2: got %b want 0", pending); end
      n_vec++; if (rh_value !== 32'h2A) begin n_err++; $display("FAIL single_rh_after: got %h want 0000002a", rh_value); end
      n_vec++; if ({flag_z, flag_n} !== 2'b00) begin n_err++; $display("FAIL single_flags: got %b%b want 00", flag_z, flag_n); end
   endtask

   task automatic test_compare_op();
      rh_addr = 4'd5;
      offer(1'b1, 4'd5, 32'h0000_1234, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      offer(1'b1, 4'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      offer(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_vec++; if ({flag_z, flag_n} !== 2'b01) begin n_err++; $display("FAIL cmp_flags_first: got %b%b want 01", flag_z, flag_n); end
      tick();
      n_vec++; if (rh_value !== 32'h1234) begin n_err++; $display("FAIL cmp_reg_unchanged: got %h want 00001234", rh_value); end
      n_vec++; if ({flag_z, flag_n} !== 2'b10) begin n_err++; $display("FAIL cmp_flags: got %b%b want 10", flag_z, flag_n); end
      // Entry with neither effect still occupies the slot for one cycle.
      offer(1'b1, 4'd5, 32'h0000_ABCD, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      offer(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL nop_pending: got %b want 1", pending); end
      tick();
      n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL nop_drained: got %b want 0", pending); end
      n_vec++; if (rh_value !== 32'h1234) begin n_err++; $display("FAIL nop_reg: got %h want 00001234", rh_value); end
      n_vec++; if ({flag_z, flag_n} !== 2'b10) begin n_err++; $display("FAIL nop_flags: got %b%b want 10", flag_z, flag_n); end
   endtask

   task automatic test_back_to_back();
      for (int t = 1; t <= 5; t++) begin
         if (t <= 4) offer(1'b1, ADDR_W'(t), DATA_W'(t * 10), 1'b0, 1'b0, 1'b1, 1'b0);
         else        offer(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
         rh_addr = ADDR_W'(t - 1);
         #1;
         n_vec++; if (wb_if.wb_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", t, wb_if.wb_ready); end
         tick();
         n_vec++; if (pending !== (t <= 4)) begin n_err++; $display("FAIL b2b_pending[%0d]: got %b want %b", t, pending, t <= 4); end
         if (t >= 2) begin
            n_vec++; if (rh_value !== DATA_W'((t - 1) * 10)) begin n_err++; $display("FAIL b2b_reg[%0d]: got %0d want %0d", t - 1, rh_value, (t - 1) * 10); end
         end
      end
   endtask

   task automatic test_stall();
      rh_addr = 4'd7;
      ro_addr = 4'd8;
      offer(1'b1, 4'd7, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      stall = 1'b1;
      offer(1'b1, 4'd8, 32'h0000_DEAD, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_vec++; if (wb_if.wb_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got %b want 0", c, wb_if.wb_ready); end
         tick();
         n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL stall_pending[%0d]: got %b want 1", c, pending); end
         n_vec++; if (rh_value !== (FWD_ON ? 32'h8000_0000 : 32'h0)) begin n_err++; $display("FAIL stall_reg7[%0d]: got %h want %h", c, rh_value, FWD_ON ? 32'h8000_0000 : 32'h0); end
         n_vec++; if (flag_n !== 1'b0) begin n_err++; $display("FAIL stall_flag_n[%0d]: got %b want 0", c, flag_n); end
      end
      stall = 1'b0;
      offer(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      n_vec++; if (rh_value !== 32'h8000_0000) begin n_err++; $display("FAIL stall_release_reg7: got %h want 80000000", rh_value); end
      n_vec++; if (flag_n !== 1'b1) begin n_err++; $display("FAIL stall_release_flag_n: got %b want 1", flag_n); end
      n_vec++; if (ro_value !== 32'h0) begin n_err++; $display("FAIL stall_reg8_not_taken: got %h want 0", ro_value); end
      n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL stall_release_pending: got %b want 0", pending); end
      // With the slot empty, stall does not block acceptance.
      stall = 1'b1;
      rh_addr = 4'd9;
      offer(1'b1, 4'd9, 32'h0000_0099, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      n_vec++; if (wb_if.wb_ready !== 1'b1) begin n_err++; $display("FAIL stall_empty_ready: got %b want 1", wb_if.wb_ready); end
      tick();
      offer(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL stall_empty_capture: got %b want 1", pending); end
      tick();
      stall = 1'b0;
      tick();
      n_vec++; if (rh_value !== 32'h99) begin n_err++; $display("FAIL stall_empty_commit: got %h want 00000099", rh_value); end
   endtask

   task automatic test_forward();
      rh_addr = 4'd2;
      ro_addr = 4'd2;
      offer(1'b1, 4'd2, 32'h0000_0011, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      offer(1'b1, 4'd2, 32'h0000_0055, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      offer(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      stall = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_vec++; if (rh_value !== (FWD_ON ? 32'h55 : 32'h11)) begin n_err++; $display("FAIL fwd_rh[%0d]: got %h want %h", c, rh_value, FWD_ON ? 32'h55 : 32'h11); end
         n_vec++; if (ro_value !== (FWD_ON ? 32'h55 : 32'h11)) begin n_err++; $display("FAIL fwd_ro[%0d]: got %h want %h", c, ro_value, FWD_ON ? 32'h55 : 32'h11); end
         tick();
      end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL fwd_reset_pending: got %b want 0", pending); end
      n_vec++; if (rh_value !== 32'h0) begin n_err++; $display("FAIL fwd_reset_reg2: got %h want 0", rh_value); end
      @(negedge clk);
      rst_n = 1'b1;
      stall = 1'b0;
      tick();
      n_vec++; if (rh_value !== 32'h0) begin n_err++; $display("FAIL fwd_no_commit: got %h want 0", rh_value); end
      n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL fwd_after_reset_pending: got %b want 0", pending); end
   endtask

   task automatic test_random();
      logic exp_rdy;
      for (int k = 0; k < 300; k++) begin
         offer($urandom_range(0, 9) < 7, ADDR_W'($urandom_range(0, NUM_REGS - 1)), $urandom,
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         stall   = ($urandom_range(0, 9) < 3);
         rh_addr = ADDR_W'($urandom_range(0, NUM_REGS - 1));
         ro_addr = ADDR_W'($urandom_range(0, NUM_REGS - 1));
         #1;
         exp_rdy = !m_pend || !stall;
         n_vec++; if (wb_if.wb_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", k, wb_if.wb_ready, exp_rdy); end
         n_vec++; if (rh_value !== exp_read(rh_addr)) begin n_err++; $display("FAIL rnd_rh[%0d]: got %h want %h", k, rh_value, exp_read(rh_addr)); end
         n_vec++; if (ro_value !== exp_read(ro_addr)) begin n_err++; $display("FAIL rnd_ro[%0d]: got %h want %h", k, ro_value, exp_read(ro_addr)); end
         tick();
         n_vec++; if (pending !== m_pend) begin n_err++; $display("FAIL rnd_pending[%0d]: got %b want %b", k, pending, m_pend); end
         n_vec++; if ({flag_z, flag_n} !== {m_z, m_n}) begin n_err++; $display("FAIL rnd_flags[%0d]: got %b%b want %b%b", k, flag_z, flag_n, m_z, m_n); end
      end
      offer(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      stall = 1'b0;
      tick();
      tick();
      for (int i = 0; i < NUM_REGS; i++) begin
         rh_addr = ADDR_W'(i);
         ro_addr = ADDR_W'(NUM_REGS - 1 - i);
         #1;
         n_vec++; if (rh_value !== m_regs[i]) begin n_err++; $display("FAIL rnd_final_rh[%0d]: got %h want %h", i, rh_value, m_regs[i]); end
         n_vec++; if (ro_value !== m_regs[NUM_REGS - 1 - i]) begin n_err++; $display("FAIL rnd_final_ro[%0d]: got %h want %h", i, ro_value, m_regs[NUM_REGS - 1 - i]); end
      end
   endtask

   initial begin
      offer(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      model_reset();
      test_reset();
      test_single_write();
      test_compare_op();
      test_back_to_back();
      test_stall();
      test_forward();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
